// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// inst_fetch_pkg
// Purpose : Shared widths, constants, fetch FSM state encoding and a PC
//           arithmetic helper for the instruction fetch stage.
// Contents: InstAddrBus / InstBus widths, ZeroWord, True_v / False_v,
//           fetch_state_e {FetchLookup, FetchMiss, FetchFill, FetchDrain},
//           pc_plus() 32-bit modulo adder.
// ============================================================================
package inst_fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = '0;
    localparam logic               True_v   = 1'b1;
    localparam logic               False_v  = 1'b0;

    typedef enum logic [1:0] {
        FetchLookup = 2'd0,
        FetchMiss   = 2'd1,
        FetchFill   = 2'd2,
        FetchDrain  = 2'd3
    } fetch_state_e;

    // Address arithmetic wraps modulo 2^32 (0xFFFF_FFFC + 4 -> 0).
    function automatic logic [InstAddrBus-1:0] pc_plus(
        input logic [InstAddrBus-1:0] pc,
        input logic [InstAddrBus-1:0] off
    );
        return pc + off;
    endfunction

endpackage

// File: rtl/fetch_byte_asm.sv
// ============================================================================
// fetch_byte_asm
// Purpose : Collects the four bytes of one instruction returned by the
//           byte-wide memory port and assembles them little-endian.
// Ports   :
//   clk, rst_n  clock, synchronous active-low reset
//   i_clear     drop any partial word and restart at byte 0 (wins over load)
//   i_load      store i_byte at byte lane o_cnt and advance the counter
//   i_byte      returned memory byte
//   o_cnt       index of the next byte to be stored (0..3)
//   o_word      assembled word, byte k in bits [8k+7:8k]
//   o_done      combinational: this load stores byte 3 (word complete)
// ============================================================================
module fetch_byte_asm
    import inst_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [7:0]         i_byte,
    output logic [1:0]         o_cnt,
    output logic [InstBus-1:0] o_word,
    output logic               o_done
);

    logic [1:0]         r_cnt;
    logic [InstBus-1:0] r_word;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt  <= 2'd0;
            r_word <= ZeroWord;
        end else if (i_load) begin
            r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
            r_cnt                        <= r_cnt + 2'd1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_word = r_word;
    assign o_done = i_load && (r_cnt == 2'd3);

endmodule

// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch
// Purpose : Instruction fetch stage. Owns the fetch PC, looks it up in the
//           instruction cache, and on a miss reads the 4-byte instruction
//           one byte at a time, fills the cache and hands the word to decode
//           through a valid/ready output register.
// Config  : FETCH_CACHE_FILL_EN defined   -> cache hits used, FILL writes cache.
//           FETCH_CACHE_FILL_EN undefined -> cache_we_o tied 0, cache_hit_i
//           ignored (every fetch goes to memory).
// Ports   :
//   RESET_PC                  PC after reset
//   clk, rst_n                clock, synchronous active-low reset
//   rdy                       global enable; low freezes state and outputs
//   redirect_i/redirect_pc_i  branch/jump redirect and its target
//   cache_rpc_o               cache lookup address (= fetch PC)
//   cache_hit_i/cache_inst_i  combinational lookup result
//   cache_we_o/wpc_o/winst_o  cache fill port
//   mem_req_o/mem_addr_o      byte read request
//   mem_gnt_i                 request accepted this cycle
//   mem_valid_i/mem_data_i    byte returned (cycle after grant)
//   inst_valid_o/inst_o/inst_pc_o  output register to decode
//   id_ready_i                decode accepts when high with inst_valid_o
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rdy,
    input  logic                   redirect_i,
    input  logic [InstAddrBus-1:0] redirect_pc_i,
    output logic [InstAddrBus-1:0] cache_rpc_o,
    input  logic                   cache_hit_i,
    input  logic [InstBus-1:0]     cache_inst_i,
    output logic                   cache_we_o,
    output logic [InstAddrBus-1:0] cache_wpc_o,
    output logic [InstBus-1:0]     cache_winst_o,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_valid_i,
    input  logic [7:0]             mem_data_i,
    output logic                   inst_valid_o,
    output logic [InstBus-1:0]     inst_o,
    output logic [InstAddrBus-1:0] inst_pc_o,
    input  logic                   id_ready_i
);

    fetch_state_e           r_state;
    fetch_state_e           w_state_d;
    logic [InstAddrBus-1:0] r_pc;
    logic                   r_outstanding;
    logic                   r_inst_valid;
    logic [InstBus-1:0]     r_inst;
    logic [InstAddrBus-1:0] r_inst_pc;

    logic                   w_hit;
    logic                   w_free;
    logic                   w_gnt_take;
    logic                   w_pending;
    logic                   w_capture;
    logic                   w_clear;
    logic                   w_done;
    logic [1:0]             w_cnt;
    logic [InstBus-1:0]     w_word;
    logic                   w_load_out;
    logic [InstBus-1:0]     w_load_data;
    logic                   w_fill_we;

`ifdef FETCH_CACHE_FILL_EN
    logic r_fill_first;

    assign w_hit = cache_hit_i;

    // Only the first FILL cycle writes; retries while decode stalls do not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill_first <= False_v;
        end else if (r_state == FetchMiss && w_done) begin
            r_fill_first <= True_v;
        end else if (rdy && r_state == FetchFill) begin
            r_fill_first <= False_v;
        end
    end

    assign w_fill_we = r_fill_first;
`else
    logic w_unused_hit;

    assign w_unused_hit = cache_hit_i;
    assign w_hit        = False_v;
    assign w_fill_we    = False_v;
`endif

    assign w_free = !r_inst_valid || id_ready_i;

    // ------------------------------------------------------------------
    // Memory handshake bookkeeping
    // ------------------------------------------------------------------
    assign w_gnt_take = mem_req_o && mem_gnt_i;

    // A byte is still owed to us after this edge: either an older request
    // whose data has not arrived yet, or a grant happening right now.
    assign w_pending = (r_outstanding && !mem_valid_i) || w_gnt_take;

    // Capture is not gated by rdy: memory keeps returning data regardless.
    assign w_capture = mem_valid_i && r_outstanding && (r_state == FetchMiss);
    assign w_clear   = rdy && (redirect_i || r_state == FetchLookup);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outstanding <= False_v;
        end else if (w_gnt_take) begin
            r_outstanding <= True_v;
        end else if (mem_valid_i) begin
            r_outstanding <= False_v;
        end
    end

    fetch_byte_asm u_byte_asm (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_clear),
        .i_load (w_capture),
        .i_byte (mem_data_i),
        .o_cnt  (w_cnt),
        .o_word (w_word),
        .o_done (w_done)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FetchLookup;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        if (rdy && redirect_i) begin
            w_state_d = w_pending ? FetchDrain : FetchLookup;
        end else begin
            case (r_state)
                FetchLookup: begin
                    if (rdy && w_free && !w_hit) begin
                        w_state_d = FetchMiss;
                    end
                end
                FetchMiss: begin
                    // Follows the byte capture, so it may fire while rdy is low.
                    if (w_done) begin
                        w_state_d = FetchFill;
                    end
                end
                FetchFill: begin
                    if (rdy && w_free) begin
                        w_state_d = FetchLookup;
                    end
                end
                FetchDrain: begin
                    if (rdy && (!r_outstanding || mem_valid_i)) begin
                        w_state_d = FetchLookup;
                    end
                end
                default: w_state_d = FetchLookup;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o     = False_v;
        mem_addr_o    = ZeroWord;
        cache_we_o    = False_v;
        cache_wpc_o   = ZeroWord;
        cache_winst_o = ZeroWord;
        w_load_out    = False_v;
        w_load_data   = cache_inst_i;
        case (r_state)
            FetchLookup: begin
                w_load_out = rdy && !redirect_i && w_free && w_hit;
            end
            FetchMiss: begin
                // One byte in flight at most.
                mem_req_o  = rdy && !r_outstanding;
                mem_addr_o = pc_plus(r_pc, {30'd0, w_cnt});
            end
            FetchFill: begin
                cache_we_o    = rdy && !redirect_i && w_fill_we;
                cache_wpc_o   = r_pc;
                cache_winst_o = w_word;
                w_load_out    = rdy && !redirect_i && w_free;
                w_load_data   = w_word;
            end
            default: ;
        endcase
    end

    assign cache_rpc_o = r_pc;

    // ------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (rdy) begin
            if (redirect_i) begin
                r_pc <= redirect_pc_i;
            end else if (w_load_out) begin
                r_pc <= pc_plus(r_pc, 32'd4);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register to decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst_valid <= False_v;
            r_inst       <= ZeroWord;
            r_inst_pc    <= ZeroWord;
        end else if (rdy) begin
            if (redirect_i) begin
                // Drop the held instruction even if decode is taking it now.
                r_inst_valid <= False_v;
            end else if (w_load_out) begin
                r_inst_valid <= True_v;
                r_inst       <= w_load_data;
                r_inst_pc    <= r_pc;
            end else if (id_ready_i) begin
                r_inst_valid <= False_v;
            end
        end
    end

    assign inst_valid_o = r_inst_valid;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;

endmodule
